report_tokenizer: RTL

- Upstream stage of the report-safety pipeline: converts the raw ASCII puzzle byte stream into the per-value strobes (read_val, en_processor, newline) consumed by the bank of skip-index safety processors.
- Parses unsigned decimal numbers separated by spaces, with lines terminated by LF.
- Tags the last value of each line with newline.
- Tracks line count and per-line value count, and flags malformed input.

---
 rtl/report_tokenizer.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/report_tokenizer.sv
// report_tokenizer
// Converts the raw ASCII puzzle byte stream into per-value strobes for the
// downstream bank of skip-index safety processors. It parses unsigned decimal
// numbers separated by spaces or tabs, with lines terminated by LF. The last
// value of each line is tagged with newline. The block also counts lines and
// values per line, and flags malformed input.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   char_in       ASCII byte, accepted when char_valid && char_ready
//   char_valid    char_in valid this cycle
//   char_ready    high in IDLE/ACCUM, low once DONE
//   eof           end-of-file pulse, honoured only while char_valid=0
//   read_val      parsed value (holds between strobes)
//   en_processor  one-cycle strobe: read_val/newline valid
//   newline       with en_processor: read_val closes its line
//   line_count    newline strobes since reset (wraps)
//   vals_in_line  values emitted so far in the current line (saturates at 15)
//   err_overflow  sticky: a number exceeded 255 (value saturated)
//   err_too_many  sticky: a line held more than MAX_VALS values
//   done          high from the cycle after DONE is entered, until reset

module report_tokenizer #(
  parameter int unsigned MAX_VALS   = 8,
  parameter int unsigned LINE_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            char_in,
  input  logic                  char_valid,
  output logic                  char_ready,
  input  logic                  eof,
  output logic [7:0]            read_val,
  output logic                  en_processor,
  output logic                  newline,
  output logic [LINE_CNT_W-1:0] line_count,
  output logic [3:0]            vals_in_line,
  output logic                  err_overflow,
  output logic                  err_too_many,
  output logic                  done
);

  localparam int unsigned VAL_W  = 8;
  localparam int unsigned ACC_W  = 12;
  localparam int unsigned VCNT_W = 4;

  localparam logic [ACC_W-1:0]  ACC_SAT  = ACC_W'(255);
  localparam logic [VCNT_W-1:0] VCNT_MAX = '1;

  // Byte codes. CR (0x0D) has no code of its own: it falls through as an
  // ignored byte, exactly like any other unrecognised character.
  localparam logic [7:0] CH_0   = 8'h30;
  localparam logic [7:0] CH_9   = 8'h39;
  localparam logic [7:0] CH_SP  = 8'h20;
  localparam logic [7:0] CH_TAB = 8'h09;
  localparam logic [7:0] CH_LF  = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [VAL_W-1:0]        acc_q, acc_d;
  logic [VAL_W-1:0]        read_val_q, read_val_d;
  logic                    en_q, en_d;
  logic                    newline_q, newline_d;
  logic [LINE_CNT_W-1:0]   line_count_q, line_count_d;
  logic [VCNT_W-1:0]       vals_q, vals_d;
  logic                    ovf_q, ovf_d;
  logic                    too_many_q, too_many_d;
  logic                    done_q, done_d;
  logic                    char_ready_q, char_ready_d;

  // Byte classification and handshake.
  logic                    accept;
  logic                    eof_evt;
  logic                    is_digit;
  logic                    is_space;
  logic                    is_lf;
  logic [3:0]              digit_val;
  logic [ACC_W-1:0]        acc_ext;

  // Emit request built by the FSM, consumed by the counter/strobe logic.
  logic                    emit;
  logic                    emit_nl;
  logic                    emit_new;
  logic [VAL_W-1:0]        emit_val;

  assign accept    = char_valid && char_ready_q;
  // A byte always wins over a (illegal) simultaneous eof.
  assign eof_evt   = eof && !char_valid;
  assign is_digit  = (char_in >= CH_0) && (char_in <= CH_9);
  assign is_space  = (char_in == CH_SP) || (char_in == CH_TAB);
  assign is_lf     = (char_in == CH_LF);
  assign digit_val = 4'(char_in - CH_0);
  // acc <= 255 so acc*10+9 <= 2559 always fits in 12 bits.
  assign acc_ext   = (ACC_W'(acc_q) * ACC_W'(10)) + ACC_W'(digit_val);

  // Next-state, emit and counter logic.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    read_val_d   = read_val_q;
    en_d         = 1'b0;
    newline_d    = 1'b0;
    line_count_d = line_count_q;
    vals_d       = vals_q;
    ovf_d        = ovf_q;
    too_many_d   = too_many_q;
    done_d       = done_q || (state_q == ST_DONE);
    char_ready_d = 1'b1;
    emit         = 1'b0;
    emit_nl      = 1'b0;
    emit_new     = 1'b0;
    emit_val     = acc_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_digit) begin
            acc_d   = VAL_W'(digit_val);
            state_d = ST_ACCUM;
          end else if (is_lf) begin
            // Nonzero count here means the line's last value went out on a
            // space; close the line by re-emitting it with newline set.
            if (vals_q != '0) begin
              emit     = 1'b1;
              emit_nl  = 1'b1;
              emit_val = read_val_q;
            end
          end
        end else if (eof_evt) begin
          if (vals_q != '0) begin
            emit     = 1'b1;
            emit_nl  = 1'b1;
            emit_val = read_val_q;
          end
          state_d = ST_DONE;
        end
      end

      ST_ACCUM: begin
        if (accept) begin
          if (is_digit) begin
            if (acc_ext > ACC_SAT) begin
              acc_d = '1;
              ovf_d = 1'b1;
            end else begin
              acc_d = acc_ext[VAL_W-1:0];
            end
          end else if (is_space || is_lf) begin
            emit     = 1'b1;
            emit_new = 1'b1;
            emit_nl  = is_lf;
            state_d  = ST_IDLE;
          end
        end else if (eof_evt) begin
          emit     = 1'b1;
          emit_new = 1'b1;
          emit_nl  = 1'b1;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_DONE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Strobe and per-line bookkeeping; a re-emit is not a new value.
    if (emit) begin
      en_d       = 1'b1;
      newline_d  = emit_nl;
      read_val_d = emit_val;
      if (state_q == ST_ACCUM) begin
        acc_d = '0;
      end
      if (emit_new && ((32'(vals_q) + 32'd1) > MAX_VALS)) begin
        too_many_d = 1'b1;
      end
      if (emit_nl) begin
        line_count_d = line_count_q + LINE_CNT_W'(1);
        vals_d       = '0;
      end else if (vals_q != VCNT_MAX) begin
        vals_d = vals_q + VCNT_W'(1);
      end
    end

    char_ready_d = (state_d != ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      read_val_q   <= '0;
      en_q         <= 1'b0;
      newline_q    <= 1'b0;
      line_count_q <= '0;
      vals_q       <= '0;
      ovf_q        <= 1'b0;
      too_many_q   <= 1'b0;
      done_q       <= 1'b0;
      char_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      read_val_q   <= read_val_d;
      en_q         <= en_d;
      newline_q    <= newline_d;
      line_count_q <= line_count_d;
      vals_q       <= vals_d;
      ovf_q        <= ovf_d;
      too_many_q   <= too_many_d;
      done_q       <= done_d;
      char_ready_q <= char_ready_d;
    end
  end

  assign char_ready   = char_ready_q;
  assign read_val     = read_val_q;
  assign en_processor = en_q;
  assign newline      = newline_q;
  assign line_count   = line_count_q;
  assign vals_in_line = vals_q;
  assign err_overflow = ovf_q;
  assign err_too_many = too_many_q;
  assign done         = done_q;

endmodule
